prog_loader: RTL and testbench

Upstream feeder for the 2-bit-opcode accumulator CPU core. It receives a program image as a byte stream from a host over a valid/ready handshake and writes it into a 64x8 program memory. It checks the image length and checksum, then raises cpu_run to release the core. While running, it serves the core's instruction fetches from that memory with one-cycle read latency.

---
 rtl/prog_loader_pkg.sv | 7 +
 rtl/prog_ram.sv | 19 +
 rtl/prog_loader.sv | 105 ++++++++++
 tb/tb_prog_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, default widths and the NOP word used by the loader and the core.
package prog_loader_pkg;
    localparam int ADDR_W_D = 6;
    localparam int DATA_W_D = 8;
    localparam logic [7:0] NOP_WORD = 8'h00;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_RUN, ST_ERROR} state_t;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: simple dual-port RAM, synchronous write port and registered read port (block-RAM friendly).
module prog_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length/data/checksum byte stream into program memory, then releases the core
// and serves its instruction fetches with one-cycle latency.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    input  logic              i_reload,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [DATA_W-1:0] o_fetch_data,
    output logic              o_cpu_run,
    output logic              o_load_error,
    output logic [ADDR_W:0]   o_load_count
);
    localparam logic [DATA_W:0] DEPTH_W = (DATA_W+1)'(DEPTH);

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_sum;
    logic              r_run;
    logic              r_err;
    logic              r_fetch_en;
    logic              w_accept;
    logic              w_we;
    logic              w_len_ok;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [DATA_W-1:0] w_rdata;

    assign o_in_ready   = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_accept     = i_in_valid && o_in_ready;
    assign w_we         = w_accept && !i_reload && (r_state == ST_LOAD);
    assign w_len_ok     = (i_in_data != '0) && ({1'b0, i_in_data} <= DEPTH_W);
    assign w_cnt_nxt    = r_cnt + 1'b1;
    assign o_cpu_run    = r_run;
    assign o_load_error = r_err;
    assign o_load_count = r_cnt;
    // Gating the RAM output with a reset register zeroes fetch_data at once on reset.
    assign o_fetch_data = r_fetch_en ? w_rdata : DATA_W'(NOP_WORD);

    prog_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_we),
        .i_waddr(r_cnt[ADDR_W-1:0]),
        .i_wdata(i_in_data),
        .i_raddr(i_fetch_addr),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_run      <= 1'b0;
            r_err      <= 1'b0;
            r_fetch_en <= 1'b0;
        end else begin
            r_fetch_en <= r_run && ({1'b0, i_fetch_addr} < r_len);
            if (i_reload) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_run   <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_len_ok) begin
                            r_len   <= i_in_data[ADDR_W:0];
                            r_sum   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                    ST_LOAD: begin
                        r_sum <= r_sum + i_in_data;
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) r_state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (i_in_data == r_sum) begin
                            r_run   <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed stimulus checked every cycle against a stream-history model.
module tb_prog_loader;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_in_valid = 1'b0;
    logic [7:0] i_in_data = '0;
    logic       o_in_ready;
    logic       i_reload = 1'b0;
    logic [5:0] i_fetch_addr = '0;
    logic [7:0] o_fetch_data;
    logic       o_cpu_run;
    logic       o_load_error;
    logic [6:0] o_load_count;

    prog_loader dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_in_valid(i_in_valid), .i_in_data(i_in_data),
        .o_in_ready(o_in_ready), .i_reload(i_reload), .i_fetch_addr(i_fetch_addr),
        .o_fetch_data(o_fetch_data), .o_cpu_run(o_cpu_run), .o_load_error(o_load_error),
        .o_load_count(o_load_count)
    );

    always #5 i_clk = ~i_clk;

    int         n_chk = 0;
    int         n_fail = 0;
    bit         chk_en = 0;
    logic [7:0] img[$];
    logic [7:0] m[64];
    logic [7:0] exp_fd = 8'h00;

    // The model derives everything from the bytes accepted since the last reset/reload.
    function automatic int m_n();
        return img.size() > 0 ? int'(img[0]) : 0;
    endfunction
    function automatic bit m_len_ok();
        return img.size() > 0 && m_n() >= 1 && m_n() <= 64;
    endfunction
    function automatic bit m_done();
        return m_len_ok() && img.size() == m_n() + 2;
    endfunction
    function automatic bit m_sum_ok();
        int s = 0;
        for (int i = 1; i <= m_n(); i++) s += int'(img[i]);
        return (s % 256) == int'(img[m_n()+1]);
    endfunction
    function automatic bit m_run();
        return m_done() && m_sum_ok();
    endfunction
    function automatic bit m_err();
        return (img.size() > 0 && !m_len_ok()) || (m_done() && !m_sum_ok());
    endfunction
    function automatic bit m_ready();
        return !(m_run() || m_err());
    endfunction
    function automatic int m_cnt();
        if (!m_len_ok()) return 0;
        return (img.size() - 1 < m_n()) ? img.size() - 1 : m_n();
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) if (chk_en) begin
        chk("in_ready", int'(o_in_ready), int'(m_ready()));
        chk("cpu_run", int'(o_cpu_run), int'(m_run()));
        chk("load_error", int'(o_load_error), int'(m_err()));
        chk("load_count", int'(o_load_count), m_cnt());
        chk("fetch_data", int'(o_fetch_data), int'(exp_fd));
    end

    task automatic cycle(input bit v, input logic [7:0] d, input bit rl, input logic [5:0] fa);
        logic [7:0] nxt_fd;
        i_in_valid = v;
        i_in_data = d;
        i_reload = rl;
        i_fetch_addr = fa;
        nxt_fd = (m_run() && int'(fa) < m_n()) ? m[fa] : 8'h00;
        @(posedge i_clk);
        exp_fd = nxt_fd;
        if (rl) img.delete();
        else if (v && m_ready()) begin
            img.push_back(d);
            if (m_len_ok() && img.size() >= 2 && img.size() - 1 <= m_n()) m[img.size()-2] = d;
        end
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_reload = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 6'($urandom));
    endtask

    task automatic reload();
        cycle(1'b0, 8'h00, 1'b1, 6'($urandom));
    endtask

    task automatic fetch(input logic [5:0] a);
        cycle(1'b0, 8'($urandom), 1'b0, a);
    endtask

    logic [7:0] nom[7] = '{8'h05, 8'h0F, 8'h0E, 8'h46, 8'hC0, 8'h81, 8'hA4};

    initial begin
        #1;
        chk("rst_fetch", int'(o_fetch_data), 0);
        chk("rst_ready", int'(o_in_ready), 1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        chk_en = 1;
        // Nominal load
        foreach (nom[i]) send(nom[i]);
        chk("nom_run", int'(o_cpu_run), 1);
        chk("nom_cnt", int'(o_load_count), 5);
        chk("nom_err", int'(o_load_error), 0);
        for (int a = 0; a < 6; a++) begin
            fetch(6'(a));
            chk("nom_fetch", int'(o_fetch_data), a < 5 ? int'(nom[a+1]) : 0);
        end
        // Bad checksum
        reload();
        send(8'h02); send(8'h11); send(8'h22); send(8'h34);
        chk("bad_err", int'(o_load_error), 1);
        chk("bad_run", int'(o_cpu_run), 0);
        chk("bad_ready", int'(o_in_ready), 0);
        fetch(6'd0);
        chk("bad_fetch", int'(o_fetch_data), 0);
        // Length bounds
        reload(); send(8'h00);
        chk("len0_err", int'(o_load_error), 1);
        reload(); send(8'h41);
        chk("len65_err", int'(o_load_error), 1);
        reload(); send(8'h40);
        for (int i = 0; i < 64; i++) send(8'h01);
        send(8'h40);
        chk("len64_run", int'(o_cpu_run), 1);
        chk("len64_cnt", int'(o_load_count), 64);
        fetch(6'd63);
        chk("len64_fetch", int'(o_fetch_data), 1);
        // Handshake stall
        reload();
        foreach (nom[i]) begin
            send(nom[i]);
            cycle(1'b0, 8'($urandom), 1'b0, 6'($urandom));
        end
        chk("stall_run", int'(o_cpu_run), 1);
        chk("stall_cnt", int'(o_load_count), 5);
        for (int a = 0; a < 5; a++) begin
            fetch(6'(a));
            chk("stall_fetch", int'(o_fetch_data), int'(nom[a+1]));
        end
        // Reload with a byte on the same edge
        cycle(1'b1, 8'h07, 1'b1, 6'd0);
        chk("rl_run", int'(o_cpu_run), 0);
        chk("rl_cnt", int'(o_load_count), 0);
        chk("rl_ready", int'(o_in_ready), 1);
        send(8'h01); send(8'hC0); send(8'hC0);
        chk("rl_load_run", int'(o_cpu_run), 1);
        fetch(6'd0);
        chk("rl_fetch", int'(o_fetch_data), 8'hC0);
        // Async reset mid-load
        reload();
        send(8'h05); send(8'h0F); send(8'h0E);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        chk("arst_cnt", int'(o_load_count), 0);
        chk("arst_run", int'(o_cpu_run), 0);
        chk("arst_ready", int'(o_in_ready), 1);
        chk("arst_fetch", int'(o_fetch_data), 0);
        img.delete();
        exp_fd = 8'h00;
        @(negedge i_clk);
        i_reset = 1'b0;
        foreach (nom[i]) send(nom[i]);
        chk("arst_reload_run", int'(o_cpu_run), 1);
        // Randomized images with gaps, bad lengths/checksums and stray reloads
        for (int t = 0; t < 40; t++) begin
            int n;
            int s;
            logic [7:0] b;
            reload();
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 255)) * int'($urandom_range(0, 1))
                                            : int'($urandom_range(1, 64));
            send(8'(n));
            s = 0;
            for (int i = 0; i < n && i < 64; i++) begin
                b = 8'($urandom);
                s += int'(b);
                if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'($urandom), 1'b0, 6'($urandom));
                if ($urandom_range(0, 199) == 0) reload();
                send(b);
            end
            send(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(s));
            for (int i = 0; i < 12; i++) cycle(1'($urandom), 8'($urandom), 1'b0, 6'($urandom_range(0, 63)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
